// File: rtl/ula_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ula_arbiter: shares one combinational ULA among N_REQ cores, RR grant.    |
// | ULA_ARB_FIXED_PRIO_EN: lowest index wins, no pointer.   Revision: 1.0     |
// +--------------------------------------------------------------------------+
module ula_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [4*N_REQ-1:0]   req_op,
  input  logic [8*N_REQ-1:0]   req_a,
  input  logic [8*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]     done,
  output logic [7:0]           rsp_result,
  output logic [3:0]           rsp_flags,
  output logic                 rsp_err,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy,
  output logic [3:0]           ula_operation,
  output logic [7:0]           ula_operand1,
  output logic [7:0]           ula_operand2,
  input  logic [7:0]           ula_result,
  input  logic [3:0]           ula_flags
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_exec = 2'd1;
  localparam logic [1:0] c_st_resp = 2'd2;
  localparam int         c_sum_w   = ID_W + 1;

  logic [1:0]       r_state;
  logic [3:0]       r_op;
  logic [7:0]       r_a;
  logic [7:0]       r_b;
  logic [ID_W-1:0]  r_id;
  logic [7:0]       r_result;
  logic [3:0]       r_flags;
  logic             r_err;

  logic [ID_W-1:0]  w_ptr;
  logic [c_sum_w-1:0] w_sum;
  logic             w_grant_found;
  logic [ID_W-1:0]  w_grant_id;
  logic [3:0]       w_sel_op;
  logic [7:0]       w_sel_a;
  logic [7:0]       w_sel_b;
  logic             w_op_valid;
  logic             w_exec;
  logic [N_REQ-1:0] w_done;

  // Scan from the pointer with wrap-around; first requesting core wins.
  always_comb begin : p_arb
    w_grant_found = 1'b0;
    w_grant_id    = '0;
    w_sum         = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, w_ptr} + c_sum_w'(k);
      if (w_sum >= c_sum_w'(N_REQ)) begin
        w_sum = w_sum - c_sum_w'(N_REQ);
      end
      if (!w_grant_found && req[w_sum[ID_W-1:0]]) begin
        w_grant_found = 1'b1;
        w_grant_id    = w_sum[ID_W-1:0];
      end
    end
  end

  always_comb begin : p_sel
    w_sel_op = 4'd0;
    w_sel_a  = 8'd0;
    w_sel_b  = 8'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant_id == ID_W'(i)) begin
        w_sel_op = req_op[4*i +: 4];
        w_sel_a  = req_a[8*i +: 8];
        w_sel_b  = req_b[8*i +: 8];
      end
    end
  end

  always_comb begin : p_done
    w_done = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_done[i] = (r_state == c_st_resp) && (r_id == ID_W'(i));
    end
  end

  // Invalid opcodes never reach the ULA, so its default path stays unused.
  assign w_op_valid = (r_op != 4'd0) && (r_op <= 4'd12);
  assign w_exec     = (r_state == c_st_exec) && w_op_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_st_idle;
      r_op     <= 4'd0;
      r_a      <= 8'd0;
      r_b      <= 8'd0;
      r_id     <= '0;
      r_result <= 8'd0;
      r_flags  <= 4'd0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (|req) begin
            r_op    <= w_sel_op;
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_id    <= w_grant_id;
            r_state <= c_st_exec;
          end else begin
            r_op <= 4'd0;
          end
        end
        c_st_exec: begin
          if (w_op_valid) begin
            r_result <= ula_result;
            r_flags  <= ula_flags;
            r_err    <= 1'b0;
          end else begin
            r_result <= 8'd0;
            r_flags  <= 4'd0;
            r_err    <= 1'b1;
          end
          r_state <= c_st_resp;
        end
        c_st_resp: begin
          r_op    <= 4'd0;
          r_state <= c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

`ifdef ULA_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [ID_W-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (r_state == c_st_resp) begin
      r_ptr <= (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + ID_W'(1);
    end
  end

  assign w_ptr = r_ptr;
`endif

  assign done          = w_done;
  assign rsp_result    = r_result;
  assign rsp_flags     = r_flags;
  assign rsp_err       = r_err;
  assign rsp_id        = r_id;
  assign busy          = (r_state != c_st_idle);
  assign ula_operation = w_exec ? r_op : 4'd0;
  assign ula_operand1  = w_exec ? r_a : 8'd0;
  assign ula_operand2  = w_exec ? r_b : 8'd0;

endmodule
`default_nettype wire

// File: tb/tb_ula_arbiter.sv
`default_nettype none
// tb_ula_arbiter: directed plus randomized transactions against a
// transaction-level model; a behavioural ULA stands in for the shared unit.
module tb_ula_arbiter;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic        clk;
  logic        rst_n;
  logic [3:0]  drv_req;
  logic [15:0] drv_op;
  logic [31:0] drv_a;
  logic [31:0] drv_b;
  logic [3:0]  done;
  logic [7:0]  rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic [1:0]  rsp_id;
  logic        busy;
  logic [3:0]  ula_operation;
  logic [7:0]  ula_operand1;
  logic [7:0]  ula_operand2;
  logic [7:0]  ula_result;
  logic [3:0]  ula_flags;

  int n_vec  = 0;
  int n_miss = 0;
  int m_ptr  = 0;

  ula_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req(drv_req), .req_op(drv_op), .req_a(drv_a), .req_b(drv_b),
    .done(done), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .rsp_err(rsp_err), .rsp_id(rsp_id), .busy(busy),
    .ula_operation(ula_operation), .ula_operand1(ula_operand1),
    .ula_operand2(ula_operand2), .ula_result(ula_result), .ula_flags(ula_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {result, V, C, S, Z}; undefined opcodes give a recognisable junk value.
  function automatic logic [11:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    logic [8:0] w;
    logic [7:0] r;
    logic       c;
    logic       v;
    w = 9'd0; r = 8'd0; c = 1'b0; v = 1'b0;
    case (op)
      4'd1: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
                  v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'd2: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8];
                  v = (a[7] != b[7]) && (r[7] != a[7]); end
      4'd3: r = a + 8'd1;
      4'd4: r = a - 8'd1;
      4'd5: r = ~a;
      4'd6: r = a & b;
      4'd7: r = a | b;
      4'd8: r = a ^ b;
      4'd9: begin r = {a[6:0], 1'b0}; c = a[7]; end
      4'd10: begin r = {1'b0, a[7:1]}; c = a[0]; end
      4'd11: r = b;
      4'd12: r = a;
      default: return 12'hEEF;
    endcase
    return {r, v, c, r[7], (r == 8'd0)};
  endfunction

  always_comb {ula_result, ula_flags} = alu_f(ula_operation, ula_operand1, ula_operand2);

  function automatic int pick(input logic [3:0] rq);
`ifdef ULA_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) if (rq[i]) return i;
`else
    for (int k = 0; k < 4; k++) if (rq[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
`endif
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic new_req(input int i, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b);
    drv_req[i]       = 1'b1;
    drv_op[4*i +: 4] = op;
    drv_a[8*i +: 8]  = a;
    drv_b[8*i +: 8]  = b;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_res"},  32'(rsp_result), 32'd0);
    check({tag, "_flg"},  32'(rsp_flags), 32'd0);
    check({tag, "_err"},  32'(rsp_err), 32'd0);
    check({tag, "_id"},   32'(rsp_id), 32'd0);
    check({tag, "_uop"},  32'(ula_operation), 32'd0);
    check({tag, "_ua"},   32'(ula_operand1), 32'd0);
    check({tag, "_ub"},   32'(ula_operand2), 32'd0);
  endtask

  // Called at a negedge while the DUT is idle with at least one request up;
  // returns at the negedge of the idle cycle that follows the response.
  task automatic serve(input bit keep, input bit early_drop, input bit perturb,
                       input logic [3:0] late);
    int          w;
    logic [3:0]  e_op;
    logic [7:0]  e_a;
    logic [7:0]  e_b;
    logic [11:0] e_rf;
    bit          e_val;
    w = pick(drv_req);
    if (w < 0) begin
      check("serve_no_request", 32'(drv_req), 32'd1);
      return;
    end
    e_op  = drv_op[4*w +: 4];
    e_a   = drv_a[8*w +: 8];
    e_b   = drv_b[8*w +: 8];
    e_val = (e_op >= 4'd1) && (e_op <= 4'd12);
    e_rf  = e_val ? alu_f(e_op, e_a, e_b) : 12'h000;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_uop", 32'(ula_operation), 32'd0);
    tick();
    if (perturb) begin
      drv_op[4*w +: 4] = 4'($urandom_range(0, 15));
      drv_a[8*w +: 8]  = 8'($urandom);
      drv_b[8*w +: 8]  = 8'($urandom);
    end
    if (early_drop) drv_req[w] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (late[i] && !drv_req[i] && i != w)
        new_req(i, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
    end
    check("exec_busy", 32'(busy), 32'd1);
    check("exec_done", 32'(done), 32'd0);
    check("exec_uop", 32'(ula_operation), 32'(e_val ? e_op : 4'd0));
    if (e_val) begin
      check("exec_ua", 32'(ula_operand1), 32'(e_a));
      check("exec_ub", 32'(ula_operand2), 32'(e_b));
    end
    tick();
    check("resp_done", 32'(done), 32'(4'b0001 << w));
    check("resp_id", 32'(rsp_id), 32'(w));
    check("resp_res", 32'(rsp_result), 32'(e_rf[11:4]));
    check("resp_flg", 32'(rsp_flags), 32'(e_rf[3:0]));
    check("resp_err", 32'(rsp_err), 32'(!e_val));
    check("resp_busy", 32'(busy), 32'd1);
    check("resp_uop", 32'(ula_operation), 32'd0);
    if (!keep) drv_req[w] = 1'b0;
    tick();
    check("post_busy", 32'(busy), 32'd0);
    check("post_done", 32'(done), 32'd0);
    check("post_res", 32'(rsp_result), 32'(e_rf[11:4]));
    check("post_err", 32'(rsp_err), 32'(!e_val));
    m_ptr = (w + 1) % N_REQ;
  endtask

  initial begin
    logic [3:0] mask;
    int         idle_n;
    rst_n = 1'b0; drv_req = 4'd0; drv_op = 16'd0; drv_a = 32'd0; drv_b = 32'd0;
    tick(); tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single request: AND F0 & 0F from core 0.
    new_req(0, 4'b0110, 8'hF0, 8'h0F);
    serve(1'b0, 1'b0, 1'b0, 4'd0);
    check("and_res_const", 32'(rsp_result), 32'h00);
    check("and_flg_const", 32'(rsp_flags), 32'h1);

    // All cores requesting at once, each drops after its done.
    for (int i = 0; i < 4; i++) new_req(i, 4'($urandom_range(1, 12)), 8'($urandom), 8'($urandom));
    for (int n = 0; n < 4; n++) serve(1'b0, 1'b0, 1'b0, 4'd0);

    // XOR FF ^ 0F from core 2.
    new_req(2, 4'b1000, 8'hFF, 8'h0F);
    serve(1'b0, 1'b0, 1'b1, 4'd0);
    check("xor_res_const", 32'(rsp_result), 32'hF0);
    check("xor_flg_const", 32'(rsp_flags), 32'h2);

    // Invalid opcode from core 1.
    new_req(1, 4'b1110, 8'h55, 8'hAA);
    serve(1'b0, 1'b0, 1'b0, 4'd0);
    check("inv_err_const", 32'(rsp_err), 32'd1);

    // Reset during EXEC: pointer is moved off zero first.
    new_req(1, 4'd1, 8'h10, 8'h20);
    serve(1'b0, 1'b0, 1'b0, 4'd0);
    new_req(2, 4'd7, 8'h0F, 8'h30);
    tick();
    check("rst_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    drv_req = 4'd0;
    m_ptr = 0;
    tick();
    check_all_zero("rst_hold");
    rst_n = 1'b1;
    tick();
    check("rst_after_done", 32'(done), 32'd0);
    tick();
    check("rst_after_done2", 32'(done), 32'd0);
    check("rst_after_busy", 32'(busy), 32'd0);
    new_req(1, 4'd2, 8'h05, 8'h09);
    new_req(3, 4'd1, 8'h7F, 8'h01);
    serve(1'b0, 1'b0, 1'b0, 4'd0);
    serve(1'b0, 1'b0, 1'b0, 4'd0);

    // Randomized traffic with re-requests, early drops and late arrivals.
    for (int it = 0; it < 150; it++) begin
      if (drv_req == 4'd0) begin
        idle_n = $urandom_range(0, 2);
        for (int j = 0; j < idle_n; j++) begin
          tick();
          check("rand_idle_done", 32'(done), 32'd0);
          check("rand_idle_busy", 32'(busy), 32'd0);
        end
        mask = 4'($urandom_range(1, 15));
        for (int i = 0; i < 4; i++)
          if (mask[i]) new_req(i, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
      end
      serve(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ula_arbiter.md
Name: ula_arbiter

Overview:
- Shares one combinational ULA (8-bit operands, 4-bit opcode, 4-bit flags {V,C,S,Z}) among N_REQ processor cores in the multiprocessor architecture.
- Arbitrates requests round-robin, drives the ULA from registered operands, and captures result and flags.
- Returns the captured result to the winning core with a one-cycle done pulse.
- Pre-screens invalid opcodes so the ULA default path is never used.

Parameters:
- N_REQ, 4, number of requesting cores (2..8).
- ID_W, 2, width of requester index; must equal clog2(N_REQ).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-core request. Held high from issue until that core's done.
- req_op  in  4*N_REQ  per-core opcode; core i uses bits [4i+3:4i].
- req_a  in  8*N_REQ  per-core operand1; core i uses bits [8i+7:8i].
- req_b  in  8*N_REQ  per-core operand2, same packing as req_a.
- done  out  N_REQ  one-hot, one-cycle completion pulse.
- rsp_result  out  8  captured result.
- rsp_flags  out  4  captured flags: [0]Z [1]S [2]C [3]V.
- rsp_err  out  1  opcode was invalid.
- rsp_id  out  ID_W  index of the core being answered.
- busy  out  1  high whenever state is not IDLE.
- ula_operation  out  4  to ULA.
- ula_operand1  out  8  to ULA.
- ula_operand2  out  8  to ULA.
- ula_result  in  8  from ULA.
- ula_flags  in  4  from ULA.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE and the RR pointer to 0.
  - All outputs are 0, including ula_operation=4'b0000.
  - An operation in flight when reset asserts is dropped and no done is issued for it.
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If req is nonzero, select the winner by round-robin starting at the pointer.
  - Latch the winner's op/a/b into op_r/a_r/b_r, latch its index into id_r, then go to EXEC.
  - If req is zero, stay in IDLE with op_r=0.
- Valid opcodes are 4'b0001..4'b1100; all others are invalid.
- EXEC, valid opcode:
  - ula_operation=op_r, ula_operand1=a_r, ula_operand2=b_r for the whole cycle.
  - At the end of the cycle, capture ula_result and ula_flags into the rsp registers and set rsp_err=0.
- EXEC, invalid opcode:
  - ula_operation=0.
  - Capture result=0, flags=0, rsp_err=1.
- RESP:
  - done[id_r]=1 for exactly one cycle; rsp_id=id_r.
  - rsp_result, rsp_flags and rsp_err stay stable until the next capture.
  - Pointer = (id_r+1) mod N_REQ.
  - op_r clears to 0, so ula_operation returns to 4'b0000; then go to IDLE.
- Timing:
  - Latency: req seen in IDLE at cycle t, done at cycle t+2.
  - Throughput: one operation per 3 cycles.
  - ULA outputs are sampled only in EXEC; the ULA's combinational path is one cycle.
- Request handshake:
  - A core drops req on the edge after its done, so IDLE never re-grants a completed request.
  - If a core drops req before done, the operation still completes and done is still pulsed.
  - A core that keeps req high after done is treated as a new request and is re-arbitrated fairly.
- Operand changes while granted are ignored; the latched copy is used.
- Simultaneous requests: with the pointer at p, the grant goes to the first set bit scanning p, p+1, ... with wrap-around.
- No new request is accepted while busy=1.

Optional Feature:
- Macro: ULA_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; the pointer register is removed and is tied to 0.
- Undefined: round-robin as specified above.

Test Plan:
- Single request:
  - Stimulus: reset, then req=0001, op 0110 (AND), a=F0, b=0F.
  - Response: done=0001 two cycles after the request is seen in IDLE; rsp_result=00, rsp_flags=0001, rsp_err=0, rsp_id=0.
- All cores requesting:
  - Stimulus: req=1111 held; each core drops req after its done.
  - Response: grants in order 0,1,2,3; done pulses spaced 3 cycles apart.
- XOR from core 2:
  - Stimulus: core 2 issues op 1000, a=FF, b=0F.
  - Response: rsp_result=F0, rsp_flags=0010; ula_operation=1000 only during EXEC, 0000 otherwise.
- Invalid opcode:
  - Stimulus: op 1110 from core 1.
  - Response: ula_operation stays 0000; rsp_result=00, rsp_flags=0, rsp_err=1, done=0010.
- Reset mid-operation:
  - Stimulus: rst_n pulsed low during EXEC.
  - Response: all outputs 0 immediately, no done pulse, pointer=0; the next request from core 3 is served normally.
- Fixed priority (ULA_ARB_FIXED_PRIO_EN defined):
  - Stimulus: cores 0 and 3 keep re-requesting.
  - Response: core 0 always wins; core 3 is granted only when req[0]=0.
